// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle decode/execute/memory/writeback control FSM for the 64-bit datapath
module multicycle_sequencer #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [SIZE-1:0]     instruction,
    input  logic                dm_ready,
    output logic [4:0]          rf_addr_a,
    output logic [4:0]          rf_addr_b,
    output logic                rf_write_enable,
    output logic [4:0]          rf_write_addr,
    output logic [1:0]          alu_op,
    output logic                alu_src_imm,
    output logic [WORDSIZE-1:0] imm,
    output logic                dm_read,
    output logic                dm_write_enable,
    output logic                wb_sel_mem,
    output logic                done,
    output logic                illegal
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [SIZE-1:0] instr;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_add, is_sub, is_and, is_or, is_addi, is_ld, is_sd;
    logic       legal;
    logic       active;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_and  = (opcode == 7'b0110011) && (funct3 == 3'b111) && (funct7 == 7'b0000000);
    assign is_or   = (opcode == 7'b0110011) && (funct3 == 3'b110) && (funct7 == 7'b0000000);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
    assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
    assign legal   = is_add | is_sub | is_and | is_or | is_addi | is_ld | is_sd;
    assign active  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            instr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid) begin
                instr <= instruction;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (instr_valid) state_next = DECODE;
            DECODE:    state_next = legal ? EXECUTE : IDLE;
            EXECUTE:   state_next = (is_ld || is_sd) ? MEMORY : WRITEBACK;
            MEMORY:    if (dm_ready) state_next = is_ld ? WRITEBACK : IDLE;
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Field outputs are visible for the whole life of an instruction; strobes only in their own state.
    always_comb begin
        instr_ready     = (state == IDLE);
        rf_addr_a       = active ? instr[19:15] : 5'd0;
        rf_addr_b       = active ? instr[24:20] : 5'd0;
        rf_write_addr   = active ? instr[11:7]  : 5'd0;
        imm             = '0;
        alu_op          = 2'b00;
        alu_src_imm     = 1'b0;
        rf_write_enable = 1'b0;
        dm_read         = 1'b0;
        dm_write_enable = 1'b0;
        wb_sel_mem      = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;

        if (active && (is_addi || is_ld)) begin
            imm = {{(WORDSIZE-12){instr[31]}}, instr[31:20]};
        end else if (active && is_sd) begin
            imm = {{(WORDSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
        end

        case (state)
            DECODE: illegal = !legal;
            EXECUTE: begin
                alu_src_imm = is_addi | is_ld | is_sd;
                if (is_sub)      alu_op = 2'b01;
                else if (is_and) alu_op = 2'b10;
                else if (is_or)  alu_op = 2'b11;
            end
            MEMORY: begin
                dm_read         = is_ld;
                dm_write_enable = is_sd;
                done            = is_sd & dm_ready;
            end
            WRITEBACK: begin
                rf_write_enable = (instr[11:7] != 5'd0);
                wb_sel_mem      = is_ld;
                done            = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer with a transaction-level reference model
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        dm_ready;
    logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
    logic        rf_write_enable;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic [63:0] imm;
    logic        dm_read, dm_write_enable, wb_sel_mem, done, illegal;

    multicycle_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .dm_ready(dm_ready),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
        .dm_read(dm_read), .dm_write_enable(dm_write_enable), .wb_sel_mem(wb_sel_mem),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        bit          mem;
        int          lat;
        logic [1:0]  aop;
        logic        asrc;
        logic [4:0]  ra, rb, rd;
        logic [63:0] imm;
        int          wen_cnt;
        logic        wbmem;
        int          rd_cnt;
        int          wr_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Expected transaction outcome, derived from the instruction's mnemonic and the cycle budget of each class.
    function automatic exp_t model(input logic [31:0] ins, input int w);
        exp_t  e;
        string m;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        m = "bad";
        if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) m = "add";
        if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) m = "sub";
        if (opc == 7'h33 && f3 == 3'd7 && f7 == 7'h00) m = "and";
        if (opc == 7'h33 && f3 == 3'd6 && f7 == 7'h00) m = "or";
        if (opc == 7'h13 && f3 == 3'd0) m = "addi";
        if (opc == 7'h03 && f3 == 3'd3) m = "ld";
        if (opc == 7'h23 && f3 == 3'd3) m = "sd";
        e.ra = ins[19:15]; e.rb = ins[24:20]; e.rd = ins[11:7];
        e.ill = (m == "bad"); e.mem = 0; e.aop = 0; e.asrc = 0; e.imm = 0;
        e.wen_cnt = 0; e.wbmem = 0; e.rd_cnt = 0; e.wr_cnt = 0;
        case (m)
            "add", "sub", "and", "or": begin
                e.lat = 3;
                e.aop = (m == "sub") ? 2'd1 : (m == "and") ? 2'd2 : (m == "or") ? 2'd3 : 2'd0;
                e.wen_cnt = (e.rd != 0) ? 1 : 0;
            end
            "addi": begin
                e.lat = 3; e.asrc = 1;
                e.imm = 64'(longint'($signed(ins[31:20])));
                e.wen_cnt = (e.rd != 0) ? 1 : 0;
            end
            "ld": begin
                e.lat = 4 + w; e.asrc = 1; e.mem = 1; e.wbmem = 1; e.rd_cnt = w + 1;
                e.imm = 64'(longint'($signed(ins[31:20])));
                e.wen_cnt = (e.rd != 0) ? 1 : 0;
            end
            "sd": begin
                e.lat = 3 + w; e.asrc = 1; e.mem = 1; e.wr_cnt = w + 1;
                e.imm = 64'(longint'($signed({ins[31:25], ins[11:7]})));
            end
            default: e.lat = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        logic [4:0]  rs1 = 5'($urandom);
        logic [4:0]  rs2 = 5'($urandom);
        logic [11:0] im  = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            1:  return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            2:  return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            3:  return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            4:  return {im, rs1, 3'd0, rd, 7'h13};
            5:  return {im, rs1, 3'd3, rd, 7'h03};
            6:  return {im[11:5], rs2, rs1, 3'd3, im[4:0], 7'h23};
            7:  return {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
            8:  return {7'h20, rs2, rs1, 3'd7, rd, 7'h33};
            9:  return {im, rs1, 3'd2, rd, 7'h03};
            10: return {im, rs1, 3'd1, rd, 7'h13};
            default: return $urandom;
        endcase
    endfunction

    // Offers one instruction and drives dm_ready so that MEMORY sees w stalled cycles before completion.
    task automatic issue(input logic [31:0] ins, input int w);
        exp_t e;
        int   n;
        e = model(ins, w);
        exp_q.push_back(e);
        instruction = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", 64'(instr_ready), 64'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instruction = $urandom;
        for (int c = 1; c <= e.lat; c++) begin
            if (e.mem && c >= 3) dm_ready = (c == 3 + w);
            else dm_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        dm_ready = 1'($urandom);
    endtask

    bit          busy = 0;
    bit          chk_idle = 0;
    int          rel;
    logic [4:0]  obs_ra, obs_rb;
    logic [1:0]  obs_aop;
    logic        obs_asrc;
    int          wen_cnt, rd_cnt, wr_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            chk_idle = 0;
        end else begin
            if (chk_idle) begin
                check("ready_after_retire", 64'(instr_ready), 64'd1);
                check("idle_quiet", 64'({rf_write_enable, dm_read, dm_write_enable, wb_sel_mem,
                                         alu_src_imm, alu_op, rf_addr_a, imm != 64'd0}), 64'd0);
                chk_idle = 0;
            end
            if (!busy) begin
                check("no_retire_when_idle", 64'({done, illegal}), 64'd0);
            end else begin
                exp_t e;
                rel++;
                if (rel == 1) begin obs_ra = rf_addr_a; obs_rb = rf_addr_b; end
                if (rel == 2) begin obs_aop = alu_op; obs_asrc = alu_src_imm; end
                wen_cnt += int'(rf_write_enable);
                rd_cnt  += int'(dm_read);
                wr_cnt  += int'(dm_write_enable);
                if (done || illegal) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("illegal_flag", 64'(illegal), 64'(e.ill));
                        check("done_flag", 64'(done), 64'(!e.ill));
                        check("latency", 64'(rel), 64'(e.lat));
                        check("rf_addr_a", 64'(obs_ra), 64'(e.ra));
                        check("rf_addr_b", 64'(obs_rb), 64'(e.rb));
                        check("rf_write_addr", 64'(rf_write_addr), 64'(e.rd));
                        check("rf_write_count", 64'(wen_cnt), 64'(e.wen_cnt));
                        check("dm_read_cycles", 64'(rd_cnt), 64'(e.rd_cnt));
                        check("dm_write_cycles", 64'(wr_cnt), 64'(e.wr_cnt));
                        if (!e.ill) begin
                            check("alu_op", 64'(obs_aop), 64'(e.aop));
                            check("alu_src_imm", 64'(obs_asrc), 64'(e.asrc));
                            check("imm", imm, e.imm);
                            check("wb_sel_mem", 64'(wb_sel_mem), 64'(e.wbmem));
                        end
                    end
                    busy = 0;
                    chk_idle = 1;
                end else if (rel > 40) begin
                    check("retire_timeout", 64'(rel), 64'd40);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    busy = 0;
                end
            end
            if (!busy && instr_valid && instr_ready) begin
                busy = 1; rel = 0; wen_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instruction = 32'h0; dm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(instr_ready), 64'd1);
        check("reset_outputs", 64'({rf_write_enable, dm_read, dm_write_enable, wb_sel_mem, done,
                                    illegal, alu_src_imm, alu_op, rf_addr_a, rf_addr_b,
                                    rf_write_addr, imm != 64'd0}), 64'd0);
        rst_n = 1'b1;

        issue(32'h002081B3, 0);
        issue(32'h402081B3, 0);
        issue(32'hFFF00293, 0);
        issue(32'h0080B303, 2);
        issue(32'h0020B823, 0);
        issue(32'h00000000, 0);
        issue(32'h00208033, 0);

        for (int i = 0; i < 200; i++) begin
            instr_valid = 1'b0;
            instruction = $urandom;
            repeat ($urandom_range(0, 2)) begin
                dm_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            issue(rand_instr(), $urandom_range(0, 3));
        end

        // Stall a load in MEMORY, then reset it away.
        instruction = 32'h0080B303; instr_valid = 1'b1; dm_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stalled_dm_read", 64'(dm_read), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_mid_memory_dm_read", 64'(dm_read), 64'd0);
        check("reset_mid_memory_ready", 64'(instr_ready), 64'd1);
        issue(32'h002081B3, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
